// File: rtl/datamemory_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port synchronous data memory.
// Each granted request runs IDLE -> ACCESS -> CAPTURE and returns a one-cycle ack.
module datamemory_arbiter #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          grant,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [1:0]    state_q,    state_d;
    logic          last_q,     last_d;
    logic          grant_q,    grant_d;
    logic          is_wr_q,    is_wr_d;
    logic          mem_ce_q,   mem_ce_d;
    logic          mem_we_q,   mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q,  mem_din_d;
    logic          ack0_q,     ack0_d;
    logic          ack1_q,     ack1_d;
    logic [DW-1:0] rdata0_q,   rdata0_d;
    logic [DW-1:0] rdata1_q,   rdata1_d;

    logic elig0, elig1, win;

    // A port whose ack is high this cycle still shows its old req; mask it.
    assign elig0 = req0 & ~ack0_q;
    assign elig1 = req1 & ~ack1_q;

    always_comb begin
        win = 1'b0;
        if (elig0 && elig1) begin
            win = ~last_q;
        end else begin
            win = elig1;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        is_wr_d    = is_wr_q;
        mem_ce_d   = mem_ce_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        case (state_q)
            IDLE: begin
                mem_ce_d = 1'b0;
                if (elig0 || elig1) begin
                    grant_d    = win;
                    last_d     = win;
                    mem_ce_d   = 1'b1;
                    mem_we_d   = win ? we1 : we0;
                    is_wr_d    = win ? we1 : we0;
                    mem_addr_d = win ? addr1 : addr0;
                    mem_din_d  = win ? wdata1 : wdata0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                mem_ce_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                if (!is_wr_q) begin
                    if (grant_q) begin
                        rdata1_d = mem_dout;
                    end else begin
                        rdata0_d = mem_dout;
                    end
                end
                ack0_d  = ~grant_q;
                ack1_d  = grant_q;
                state_d = IDLE;
            end
            default: begin
                mem_ce_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            grant_q    <= 1'b0;
            is_wr_q    <= 1'b0;
            mem_ce_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            is_wr_q    <= is_wr_d;
            mem_ce_q   <= mem_ce_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = (state_q != IDLE);
    assign grant    = grant_q;
    assign mem_ce   = mem_ce_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: doc/datamemory_arbiter.md
# datamemory_arbiter

Two-port round-robin arbiter and sequencer in front of the single-port synchronous data memory (6-bit word address, 32-bit data, `ce`/`we` control, registered read data). It lets two requesters, such as the CPU load/store unit and a loader/DMA engine, share the memory. Each requester gets a simple req/ack transaction interface. The block owns every memory control strobe.

## Interface
- `AW`, 6, memory word-address width
- `DW`, 32, data width
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0` / `req1` in 1: request; held high until the matching ack.
- `we0` / `we1` in 1: 1 = write, 0 = read. Qualified by req.
- `addr0` / `addr1` in AW: word address.
- `wdata0` / `wdata1` in DW: write data.
- `ack0` / `ack1` out 1: one-cycle completion pulse, registered.
- `rdata0` / `rdata1` out DW: read data, valid while the ack is high; held until that port's next read completes.
- `busy` out 1: high while a transaction is in flight (ACCESS or CAPTURE).
- `grant` out 1: index of the port owning the current or most recent transaction.
- `mem_ce`, `mem_we` out 1: memory chip enable and write enable, registered.
- `mem_addr` out AW, `mem_din` out DW: memory address and write data, registered.
- `mem_dout` in DW: memory read data. It is valid in the cycle after a `ce=1, we=0` edge.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE.
- IDLE: `mem_ce=0`.
  - A port is eligible if its req=1 and its ack is not high in this cycle. The ack-cycle mask prevents re-granting a stale request.
  - Neither port eligible: stay in IDLE.
  - Exactly one port eligible: grant it.
  - Both ports eligible: grant the port that was not granted last (round-robin pointer `last`).
  - On grant: latch the winner's we/addr/wdata into `mem_we/mem_addr/mem_din`, set `mem_ce=1`, set `grant` and `last` to the winner, then go to ACCESS.
- ACCESS: the memory performs the operation at the closing edge. Then `mem_ce<=0`, `mem_we<=0`, and the state goes to CAPTURE.
- CAPTURE:
  - For a read, register `mem_dout` into `rdata[grant]` at the closing edge.
  - For a write, leave `rdata` unchanged.
  - Pulse `ack[grant]` for the next cycle, then go to IDLE.
- Requester inputs are sampled only at the grant edge. Changes after the grant are ignored until the next grant.
- The non-granted port's request waits and is never dropped. Round-robin guarantees it is served next.
- `busy` = (state != IDLE).
- Reset values: state IDLE, `mem_ce=0`, `mem_we=0`, `mem_addr=0`, `mem_din=0`, `ack0=ack1=0`, `rdata0=rdata1=0`, `grant=0`, `last=1` (port 0 wins the first conflict), `busy=0`.
- Reset mid-transaction: all registers return to their reset values at that edge and no ack is issued. A write whose ACCESS cycle coincides with the reset edge still commits, because the strobes were already registered. The requester must re-issue after reset.

## Timing
- Request sampled in IDLE at edge E0.
- Cycle after E0: ACCESS, with `mem_ce=1` on the bus.
- Next cycle: CAPTURE.
- Next cycle: ack=1 and rdata valid. Req-to-ack latency is 3 cycles for both reads and writes.
- The ack cycle is IDLE. The other port can be granted in that same cycle, so sustained alternating throughput is one access per 3 cycles.
- The same port re-requesting straight after its ack is granted one cycle later, because of the ack-cycle mask.
- `mem_ce` is high for exactly one cycle per transaction and is never high in IDLE or CAPTURE.

## Test plan
- **Single read.** Memory preloaded with mem[1]=5000. `req0=1, we0=0, addr0=1`.
  - `mem_ce` high in exactly one cycle.
  - `ack0` pulses 3 cycles after the request edge with `rdata0=5000`.
  - `ack1` stays 0.
- **Write then read-back.** Port 1 writes 32'hDEADBEEF to address 63. Port 1 then reads address 63.
  - `ack1` for the write; `rdata1` unchanged.
  - Second `ack1` carries `rdata1`=32'hDEADBEEF.
  - `mem_addr`=63 on both ACCESS cycles.
- **Simultaneous requests from reset.** Both ports read, port 0 addr 0 (1000) and port 1 addr 3 (3000), held high continuously.
  - Port 0 is served first.
  - Acks alternate 0,1,0,1 every 3 cycles.
  - `rdata0=1000`, `rdata1=3000`.
  - No port is granted twice in a row.
- **Input change after grant.** Change `addr0` from 2 to 5 in the ACCESS cycle.
  - The memory sees address 2.
  - `rdata0=2000`.
- **Reset during CAPTURE of a read.**
  - Next cycle: `ack0=0`, `rdata0=0`, `busy=0`, `mem_ce=0`.
  - After reset is released, a held `req0` is re-granted and completes normally.
- **Back-to-back same port.** `req0` held high for 2 reads.
  - Acks are 4 cycles apart (one mask cycle).
  - Exactly 2 `mem_ce` pulses.
